// File: rtl/adc_pkg.sv
// adc_pkg: shared definitions for the SPI ADC capture block.
//   - estado_t      : capture FSM encoding (IDLE, SETUP, SHIFT, DONE)
//   - FRAME_BITS    : SPI frame length in bits
//   - ADC_BITS      : ADC code width (offset binary)
//   - OUT_W         : width of the signed output word
//   - FRAC_SHIFT    : left shift placing the code in Q12.16
//   - codigo_a_datos: offset-binary code -> sign-extended, scaled output word
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } estado_t;

    localparam int FRAME_BITS   = 16;
    localparam int ADC_BITS     = 12;
    localparam int OUT_W        = 29;
    localparam int FRAC_SHIFT   = 5;

    // SCLK half-periods spent in SHIFT: 31 toggles plus the final high half.
    localparam int HALF_PERIODS = 2 * FRAME_BITS;

    // Flipping the MSB turns offset binary into two's complement (code - 2048).
    function automatic logic [OUT_W-1:0] codigo_a_datos(input logic [ADC_BITS-1:0] code);
        logic [ADC_BITS-1:0] s;
        s = {~code[ADC_BITS-1], code[ADC_BITS-2:0]};
        return {{(OUT_W - ADC_BITS - FRAC_SHIFT){s[ADC_BITS-1]}}, s, {FRAC_SHIFT{1'b0}}};
    endfunction

endpackage

// File: rtl/gen_tick_muestreo.sv
// gen_tick_muestreo: modulo-N counter producing a one-cycle tick.
//   clk  in  system clock
//   rst  in  asynchronous active-high reset
//   en   in  count enable; when low the count is held at 0
//   tick out high for one cycle when the count is N-1
module gen_tick_muestreo #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(N - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = en && (cnt == CNT_W'(N - 1));

endmodule

// File: rtl/adc_spi_captura.sv
// adc_spi_captura: periodic capture of one 12-bit sample from an SPI ADC.
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   spi_miso    in   ADC serial data, sampled on the edge that drives SCLK high
//   spi_cs_n    out  ADC chip select, active low
//   spi_sclk    out  SPI clock, idles high, first edge of a frame is falling
//   Datos       out  signed Q12.16 sample, held between strobes
//   Dato_Listo  out  one-cycle strobe, Datos is new this cycle
//   Overrun     out  sticky, set when a sample tick arrives while busy
//
// state | meaning
// IDLE  | bus idle, waiting for the sample tick
// SETUP | chip select low, CS-to-first-edge delay of CLK_DIV cycles
// SHIFT | SCLK running, 16 bits shifted in on rising edges
// DONE  | chip select released, Datos updated, strobe high
module adc_spi_captura
    import adc_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 2000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_miso,
    output logic             spi_cs_n,
    output logic             spi_sclk,
    output logic [OUT_W-1:0] Datos,
    output logic             Dato_Listo,
    output logic             Overrun
);

    localparam int N_W = $clog2(HALF_PERIODS + 1);

    estado_t             estado;
    logic                tick_muestra;
    logic                tick_medio;
    logic                en_medio;
    logic [ADC_BITS-1:0] trama;
    logic [N_W-1:0]      n_medios;

    gen_tick_muestreo #(.N(SAMPLE_PERIOD)) u_tick_muestra (
        .clk  (clk),
        .rst  (rst),
        .en   (1'b1),
        .tick (tick_muestra)
    );

    assign en_medio = (estado == SETUP) || (estado == SHIFT);

    gen_tick_muestreo #(.N(CLK_DIV)) u_tick_medio (
        .clk  (clk),
        .rst  (rst),
        .en   (en_medio),
        .tick (tick_medio)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado     <= IDLE;
            spi_cs_n   <= 1'b1;
            spi_sclk   <= 1'b1;
            Datos      <= '0;
            Dato_Listo <= 1'b0;
            Overrun    <= 1'b0;
            trama      <= '0;
            n_medios   <= '0;
        end else begin
            Dato_Listo <= 1'b0;

            if (tick_muestra && (estado != IDLE)) begin
                Overrun <= 1'b1;
            end

            case (estado)
                IDLE: begin
                    if (tick_muestra) begin
                        estado   <= SETUP;
                        spi_cs_n <= 1'b0;
                    end
                end
                SETUP: begin
                    if (tick_medio) begin
                        estado   <= SHIFT;
                        spi_sclk <= 1'b0;
                        n_medios <= '0;
                    end
                end
                SHIFT: begin
                    // One guard cycle after the final high half keeps CS low
                    // for 33*CLK_DIV+1 cycles in total.
                    if (n_medios == N_W'(HALF_PERIODS)) begin
                        estado     <= DONE;
                        spi_cs_n   <= 1'b1;
                        Datos      <= codigo_a_datos(trama);
                        Dato_Listo <= 1'b1;
                    end else if (tick_medio) begin
                        n_medios <= n_medios + N_W'(1);
                        if (n_medios < N_W'(HALF_PERIODS - 1)) begin
                            spi_sclk <= ~spi_sclk;
                            // The four leading frame bits fall off the top
                            // of the 12-bit register.
                            if (!spi_sclk) begin
                                trama <= {trama[ADC_BITS-2:0], spi_miso};
                            end
                        end
                    end
                end
                DONE: begin
                    estado <= IDLE;
                end
                default: begin
                    estado <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_captura.sv
// tb_adc_spi_captura: self-checking bench for adc_spi_captura.
//   Main instance (CLK_DIV=4, SAMPLE_PERIOD=400) driven by an SPI ADC model;
//   three side instances (SAMPLE_PERIOD=100/134/135) for overrun boundaries.
module tb_adc_spi_captura;

    localparam int D  = 4;
    localparam int SP = 400;

    logic        clk;
    logic        rst;
    logic        spi_miso;
    logic        spi_cs_n;
    logic        spi_sclk;
    logic [28:0] Datos;
    logic        Dato_Listo;
    logic        Overrun;

    logic        rst_ov;
    logic        miso_cero;
    logic        cs_a, sclk_a, dl_a, ov_a;
    logic        cs_b, sclk_b, dl_b, ov_b;
    logic        cs_c, sclk_c, dl_c, ov_c;
    logic [28:0] datos_a, datos_b, datos_c;

    int n_checks;
    int n_err;

    logic [15:0] next_frame;
    logic [15:0] adc_frame;
    int          bit_idx;

    adc_spi_captura #(.CLK_DIV(D), .SAMPLE_PERIOD(SP)) dut (
        .clk(clk), .rst(rst), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n),
        .spi_sclk(spi_sclk), .Datos(Datos), .Dato_Listo(Dato_Listo), .Overrun(Overrun)
    );

    adc_spi_captura #(.CLK_DIV(D), .SAMPLE_PERIOD(100)) dut_a (
        .clk(clk), .rst(rst_ov), .spi_miso(miso_cero), .spi_cs_n(cs_a),
        .spi_sclk(sclk_a), .Datos(datos_a), .Dato_Listo(dl_a), .Overrun(ov_a)
    );

    adc_spi_captura #(.CLK_DIV(D), .SAMPLE_PERIOD(134)) dut_b (
        .clk(clk), .rst(rst_ov), .spi_miso(miso_cero), .spi_cs_n(cs_b),
        .spi_sclk(sclk_b), .Datos(datos_b), .Dato_Listo(dl_b), .Overrun(ov_b)
    );

    adc_spi_captura #(.CLK_DIV(D), .SAMPLE_PERIOD(135)) dut_c (
        .clk(clk), .rst(rst_ov), .spi_miso(miso_cero), .spi_cs_n(cs_c),
        .spi_sclk(sclk_c), .Datos(datos_c), .Dato_Listo(dl_c), .Overrun(ov_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ADC model: frame latched at CS fall, next bit presented on each SCLK fall.
    always @(negedge spi_cs_n) begin
        adc_frame = next_frame;
        bit_idx   = 0;
    end

    always @(negedge spi_sclk) begin
        if (spi_cs_n === 1'b0) begin
            if (bit_idx < 16) spi_miso = adc_frame[15 - bit_idx];
            bit_idx++;
        end
    end

    function automatic logic [28:0] modelo(input logic [15:0] frame);
        int v;
        v = int'(frame & 16'h0FFF) - 2048;
        return 29'(v * 32);
    endfunction

    // Cycle 1 = first cycle with CS low; SCLK low between falling and rising edges.
    function automatic logic sclk_esperado(input int c);
        for (int k = 1; k <= 16; k++) begin
            if (c >= 1 + (2 * k - 1) * D && c < 1 + 2 * k * D) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic sel_cs(input int i);
        case (i)
            0:       return cs_a;
            1:       return cs_b;
            default: return cs_c;
        endcase
    endfunction

    function automatic logic sel_ov(input int i);
        case (i)
            0:       return ov_a;
            1:       return ov_b;
            default: return ov_c;
        endcase
    endfunction

    function automatic logic sel_sclk(input int i);
        case (i)
            0:       return sclk_a;
            1:       return sclk_b;
            default: return sclk_c;
        endcase
    endfunction

    function automatic logic sel_dl(input int i);
        case (i)
            0:       return dl_a;
            1:       return dl_b;
            default: return dl_c;
        endcase
    endfunction

    function automatic logic [28:0] sel_datos(input int i);
        case (i)
            0:       return datos_a;
            1:       return datos_b;
            default: return datos_c;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic esperar_caida(output bit ok, output int n);
        logic prev;
        prev = spi_cs_n;
        n    = 0;
        ok   = 1'b0;
        while (n < 3 * SP) begin
            @(negedge clk);
            n++;
            if (prev === 1'b1 && spi_cs_n === 1'b0) begin
                ok = 1'b1;
                break;
            end
            prev = spi_cs_n;
        end
    endtask

    // Called on the negedge of cycle 1; walks the whole frame.
    task automatic revisar_trama(input logic [28:0] exp, input string tag);
        int          err_sclk;
        int          err_cs;
        int          err_dl;
        logic [28:0] d_strobe;
        err_sclk = 0;
        err_cs   = 0;
        err_dl   = 0;
        d_strobe = 'x;
        for (int c = 1; c <= 4 + 33 * D; c++) begin
            if (c > 1) @(negedge clk);
            if (spi_sclk !== sclk_esperado(c)) err_sclk++;
            if (spi_cs_n !== ((c <= 1 + 33 * D) ? 1'b0 : 1'b1)) err_cs++;
            if (Dato_Listo !== (c == 2 + 33 * D)) err_dl++;
            if (c == 2 + 33 * D) d_strobe = Datos;
        end
        chk({tag, " sclk_wave_errs"}, err_sclk, 0);
        chk({tag, " cs_n_wave_errs"}, err_cs, 0);
        chk({tag, " strobe_errs"}, err_dl, 0);
        chk({tag, " datos_at_strobe"}, d_strobe, exp);
        chk({tag, " datos_held"}, Datos, exp);
    endtask

    task automatic run_conv(input logic [15:0] frame, input logic [28:0] exp,
                            input string tag, output int n);
        bit ok;
        next_frame = frame;
        esperar_caida(ok, n);
        chk({tag, " cs_fall_seen"}, ok, 1);
        if (ok) revisar_trama(exp, tag);
    endtask

    task automatic ov_caso(input int idx, input int N);
        bit   dropped;
        bit   ok;
        int   n;
        int   bad;
        logic prev;
        string tag;
        tag     = $sformatf("ov_N%0d", N);
        // Busy from the tick (cycle 0) through DONE (cycle 2+33*D).
        dropped = (N <= 2 + 33 * D);
        rst_ov  = 1'b1;
        #1;
        chk({tag, " rst_sclk"}, sel_sclk(idx), 1);
        chk({tag, " rst_datos"}, sel_datos(idx), 0);
        chk({tag, " rst_strobe"}, sel_dl(idx), 0);
        repeat (3) @(negedge clk);
        rst_ov = 1'b0;
        prev = sel_cs(idx);
        ok   = 1'b0;
        n    = 0;
        while (n < N + 5) begin
            @(negedge clk);
            n++;
            if (prev === 1'b1 && sel_cs(idx) === 1'b0) begin
                ok = 1'b1;
                break;
            end
            prev = sel_cs(idx);
        end
        chk({tag, " first_cs_fall"}, ok, 1);
        if (ok) begin
            for (int c = 2; c <= N + 1; c++) begin
                @(negedge clk);
                if (c == N) chk({tag, " overrun_before_tick2"}, sel_ov(idx), 0);
                if (c == N + 1) begin
                    chk({tag, " overrun_after_tick2"}, sel_ov(idx), 32'(dropped));
                    chk({tag, " cs_n_after_tick2"}, sel_cs(idx),
                        32'(!((N + 1 <= 1 + 33 * D) || !dropped)));
                end
            end
            bad = 0;
            repeat (5 * N) begin
                @(negedge clk);
                if (sel_ov(idx) !== dropped) bad++;
            end
            chk({tag, " overrun_sticky_errs"}, bad, 0);
            if (dropped) begin
                rst_ov = 1'b1;
                #1;
                chk({tag, " overrun_cleared_by_rst"}, sel_ov(idx), 0);
            end
        end
    endtask

    typedef struct {
        logic [15:0] frame;
        logic [28:0] exp;
        string       name;
    } vec_t;

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tabla[5];
        int   n;
        bit   ok;

        tabla[0] = '{16'h0800, 29'h0000000,  "code_800"};
        tabla[1] = '{16'h0FFF, 29'h000FFE0,  "code_FFF"};
        tabla[2] = '{16'h0000, 29'h1FFF0000, "code_000"};
        tabla[3] = '{16'h0801, 29'h0000020,  "code_801"};
        tabla[4] = '{16'hF7FF, 29'h1FFFFFE0, "frame_F7FF"};

        n_checks   = 0;
        n_err      = 0;
        rst        = 1'b1;
        rst_ov     = 1'b1;
        spi_miso   = 1'b0;
        miso_cero  = 1'b0;
        next_frame = 16'h0000;
        bit_idx    = 0;
        #1;
        chk("rst cs_n", spi_cs_n, 1);
        chk("rst sclk", spi_sclk, 1);
        chk("rst datos", Datos, 0);
        chk("rst strobe", Dato_Listo, 0);
        chk("rst overrun", Overrun, 0);
        repeat (3) @(negedge clk);

        fork
            begin
                rst = 1'b0;
                run_conv(tabla[0].frame, tabla[0].exp, tabla[0].name, n);
                chk("first_tick_cycles_ok", (n >= SP && n <= SP + 1), 1);
                for (int i = 1; i < 5; i++) begin
                    run_conv(tabla[i].frame, tabla[i].exp, tabla[i].name, n);
                end
                for (int i = 0; i < 8; i++) begin
                    logic [15:0] f;
                    f = 16'($urandom);
                    run_conv(f, modelo(f), $sformatf("rand%0d_%04h", i, f), n);
                end

                run_conv(16'h0FFF, 29'h000FFE0, "pre_reset", n);
                next_frame = 16'h0ABC;
                esperar_caida(ok, n);
                chk("midrst cs_fall_seen", ok, 1);
                if (ok) begin
                    int   c;
                    int   rises;
                    logic prev_s;
                    int   dl_cnt;
                    c      = 1;
                    rises  = 0;
                    prev_s = spi_sclk;
                    while (rises < 8 && c < 200) begin
                        @(negedge clk);
                        c++;
                        if (!prev_s && spi_sclk) rises++;
                        prev_s = spi_sclk;
                    end
                    chk("midrst rise8_cycle", c, 1 + 16 * D);
                    rst = 1'b1;
                    #1;
                    chk("midrst cs_n", spi_cs_n, 1);
                    chk("midrst sclk", spi_sclk, 1);
                    chk("midrst datos", Datos, 0);
                    chk("midrst strobe", Dato_Listo, 0);
                    dl_cnt = 0;
                    repeat (3) begin
                        @(negedge clk);
                        if (Dato_Listo !== 1'b0 || spi_cs_n !== 1'b1) dl_cnt++;
                    end
                    chk("midrst bus_idle_during_rst", dl_cnt, 0);
                    rst = 1'b0;
                    next_frame = 16'h0123;
                    esperar_caida(ok, n);
                    chk("postrst cs_fall_seen", ok, 1);
                    chk("postrst tick_cycles_ok", (n >= SP && n <= SP + 1), 1);
                    chk("postrst no_strobe_datos", Datos, 0);
                    if (ok) revisar_trama(modelo(16'h0123), "postrst");
                end
                chk("main overrun_clear", Overrun, 0);
            end
            begin
                ov_caso(0, 100);
                ov_caso(1, 134);
                ov_caso(2, 135);
            end
        join

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
